// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and command in,
// handshake, results and flags out.
interface seq_alu_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] op1;
  logic [N-1:0] op2;
  logic [3:0]   cmd;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic [N-1:0] out_hi;
  logic         over;
  logic         under;
  logic         err;
  logic         log;

  modport master (
    output start, op1, op2, cmd,
    input  busy, done, out, out_hi, over, under, err, log
  );

  modport slave (
    input  start, op1, op2, cmd,
    output busy, done, out, out_hi, over, under, err, log
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle ops finish in one cycle, shift-add
// multiply and restoring divide iterate N cycles in RUN.
module seq_alu #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  opnd_reg, opnd_next;
  logic [N-1:0]  hi_reg, hi_next;
  logic [N-1:0]  lo_reg, lo_next;
  logic          mul_reg, mul_next;
  logic [N-1:0]  out_reg, out_next;
  logic [N-1:0]  out_hi_reg, out_hi_next;
  logic          over_reg, over_next;
  logic          under_reg, under_next;
  logic          err_reg, err_next;
  logic          log_reg, log_next;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic          div_ge;
  logic [N-1:0]  step_hi, step_lo;

  // One iteration: mul keeps {hi, lo} as partial product with the multiplier
  // shifting out of lo; div keeps the remainder in hi and the quotient in lo.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(N+1){1'b0}});
    div_shift = {hi_reg, lo_reg[N-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    if (mul_reg) begin
      step_hi = mul_sum[N:1];
      step_lo = {mul_sum[0], lo_reg[N-1:1]};
    end else begin
      step_hi = div_ge ? N'(div_shift - {1'b0, opnd_reg}) : div_shift[N-1:0];
      step_lo = {lo_reg[N-2:0], div_ge};
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    opnd_next   = opnd_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    mul_next    = mul_reg;
    out_next    = out_reg;
    out_hi_next = out_hi_reg;
    over_next   = over_reg;
    under_next  = under_reg;
    err_next    = err_reg;
    log_next    = log_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          out_next    = '0;
          out_hi_next = '0;
          over_next   = 1'b0;
          under_next  = 1'b0;
          err_next    = 1'b0;
          log_next    = 1'b0;
          state_next  = DONE;
          case (bus.cmd)
            4'd0: {over_next, out_next} = {1'b0, bus.op1} + {1'b0, bus.op2};
            4'd1: begin
              out_next   = bus.op1 - bus.op2;
              under_next = (bus.op1 < bus.op2);
            end
            // Logical shifts by N or more already produce zero.
            4'd2: out_next = bus.op1 << bus.op2;
            4'd3: out_next = bus.op1 >> bus.op2;
            4'd4: log_next = (bus.op1 == bus.op2);
            4'd5: log_next = (bus.op1 > bus.op2);
            4'd6: log_next = (bus.op1 < bus.op2);
            4'd7: begin
              state_next = RUN;
              mul_next   = 1'b1;
              opnd_next  = bus.op1;
              lo_next    = bus.op2;
              hi_next    = '0;
              cnt_next   = CW'(N);
            end
            4'd8: begin
              if (bus.op2 == '0) begin
                err_next    = 1'b1;
                out_next    = '1;
                out_hi_next = bus.op1;
              end else begin
                state_next = RUN;
                mul_next   = 1'b0;
                opnd_next  = bus.op2;
                lo_next    = bus.op1;
                hi_next    = '0;
                cnt_next   = CW'(N);
              end
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      RUN: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next  = DONE;
          out_next    = step_lo;
          out_hi_next = step_hi;
          over_next   = mul_reg && (step_hi != '0);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mul_reg    <= 1'b0;
      out_reg    <= '0;
      out_hi_reg <= '0;
      over_reg   <= 1'b0;
      under_reg  <= 1'b0;
      err_reg    <= 1'b0;
      log_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      opnd_reg   <= opnd_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      mul_reg    <= mul_next;
      out_reg    <= out_next;
      out_hi_reg <= out_hi_next;
      over_reg   <= over_next;
      under_reg  <= under_next;
      err_reg    <= err_next;
      log_reg    <= log_next;
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.out    = out_reg;
  assign bus.out_hi = out_hi_reg;
  assign bus.over   = over_reg;
  assign bus.under  = under_reg;
  assign bus.err    = err_reg;
  assign bus.log    = log_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (N=8): vector table through a scoreboard, plus hand
// sequences for start-held-during-RUN, back-to-back accept and reset abort.
module tb_seq_alu;
  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] out;
    logic [N-1:0] out_hi;
    logic         over;
    logic         under;
    logic         err;
    logic         log;
  } res_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   c;
    res_t         r;
  } vec_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   chk_lat;
    int   lat;
  } exp_t;

  typedef struct {
    res_t r;
    int   cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_q[$];
  obs_t obs_q[$];
  vec_t vec[20];

  seq_alu_if #(.N(N)) bus ();
  seq_alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every done pulse with the cycle it was seen in.
  always @(negedge clk) begin
    obs_t o;
    if (bus.done) begin
      o.r   = {bus.out, bus.out_hi, bus.over, bus.under, bus.err, bus.log};
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c,
                              input logic [N-1:0] o, input logic [N-1:0] h,
                              input logic ov, input logic un, input logic er, input logic lg);
    vec_t v;
    v.a = a; v.b = b; v.c = c;
    v.r = {o, h, ov, un, er, lg};
    return v;
  endfunction

  function automatic int lat_of(input logic [3:0] c, input logic [N-1:0] b);
    return (c == 4'd7 || (c == 4'd8 && b != '0)) ? N + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    obs_t o;
    check({tag, " done_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, " result"}, o.r, e.r);
      if (e.chk_lat) check({tag, " latency"}, o.cyc - e.acc + 1, e.lat);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // One request from idle; after done, results must hold with busy low.
  task automatic issue(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    bus.op1 = v.a; bus.op2 = v.b; bus.cmd = v.c; bus.start = 1'b1;
    e.r = v.r; e.acc = cyc + 1; e.chk_lat = 1'b1; e.lat = lat_of(v.c, v.b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op1 = N'($urandom); bus.op2 = N'($urandom); bus.cmd = 4'($urandom_range(0, 15));
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) @(posedge clk);
    #1;
    check($sformatf("held cmd=%0d a=%0d b=%0d", v.c, v.a, v.b),
          {bus.busy, bus.done, bus.out, bus.out_hi, bus.over, bus.under, bus.err, bus.log},
          {2'b00, v.r});
  endtask

  initial begin
    exp_t e;
    vec[0]  = mk(8'd8,   8'd3,   4'd7, 8'h18, 8'h00, 0, 0, 0, 0);
    vec[1]  = mk(8'd255, 8'd255, 4'd7, 8'h01, 8'hFE, 1, 0, 0, 0);
    vec[2]  = mk(8'd0,   8'd200, 4'd7, 8'h00, 8'h00, 0, 0, 0, 0);
    vec[3]  = mk(8'd200, 8'd7,   4'd8, 8'd28, 8'd4,  0, 0, 0, 0);
    vec[4]  = mk(8'd50,  8'd0,   4'd8, 8'hFF, 8'd50, 0, 0, 1, 0);
    vec[5]  = mk(8'd200, 8'd100, 4'd0, 8'd44, 8'd0,  1, 0, 0, 0);
    vec[6]  = mk(8'd5,   8'd9,   4'd1, 8'd252, 8'd0, 0, 1, 0, 0);
    vec[7]  = mk(8'd1,   8'd9,   4'd2, 8'd0,  8'd0,  0, 0, 0, 0);
    vec[8]  = mk(8'd9,   8'd5,   4'd5, 8'd0,  8'd0,  0, 0, 0, 1);
    vec[9]  = mk(8'd3,   8'd4,   4'd12, 8'd0, 8'd0,  0, 0, 1, 0);
    vec[10] = mk(8'hF0,  8'd4,   4'd3, 8'h0F, 8'd0,  0, 0, 0, 0);
    vec[11] = mk(8'd7,   8'd7,   4'd4, 8'd0,  8'd0,  0, 0, 0, 1);
    vec[12] = mk(8'd9,   8'd5,   4'd6, 8'd0,  8'd0,  0, 0, 0, 0);
    vec[13] = mk(8'd3,   8'd4,   4'd0, 8'd7,  8'd0,  0, 0, 0, 0);
    vec[14] = mk(8'h81,  8'd1,   4'd2, 8'h02, 8'd0,  0, 0, 0, 0);
    vec[15] = mk(8'd255, 8'd16,  4'd8, 8'd15, 8'd15, 0, 0, 0, 0);
    vec[16] = mk(8'd9,   8'd5,   4'd1, 8'd4,  8'd0,  0, 0, 0, 0);
    vec[17] = mk(8'd16,  8'd16,  4'd7, 8'h00, 8'h01, 1, 0, 0, 0);
    vec[18] = mk(8'h80,  8'd8,   4'd3, 8'd0,  8'd0,  0, 0, 0, 0);
    vec[19] = mk(8'd5,   8'd9,   4'd15, 8'd0, 8'd0,  0, 0, 1, 0);

    bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.cmd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {bus.busy, bus.done, bus.out, bus.out_hi, bus.over, bus.under, bus.err, bus.log}, '0);
    rst = 1'b0;

    foreach (vec[i]) begin
      issue(vec[i]);
      drain($sformatf("vec%0d cmd=%0d", i, vec[i].c));
      $display("vec%0d cmd=%0d a=%0d b=%0d done", i, vec[i].c, vec[i].a, vec[i].b);
    end

    // mul 8x3, start held high with new operands through RUN; the held
    // request (add 100+100) must be accepted on the edge after done drops.
    @(posedge clk); #1;
    bus.op1 = 8'd8; bus.op2 = 8'd3; bus.cmd = 4'd7; bus.start = 1'b1;
    e.r = {8'h18, 8'h00, 4'b0000}; e.acc = cyc + 1; e.chk_lat = 1'b1; e.lat = N + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.op1 = 8'd100; bus.op2 = 8'd100; bus.cmd = 4'd0;
    e.r = {8'd200, 8'd0, 4'b0000}; e.acc = e.acc + N + 2; e.chk_lat = 1'b1; e.lat = 1;
    exp_q.push_back(e);
    for (int k = 1; k <= N + 1; k++) begin
      check($sformatf("held_start busy k=%0d", k), bus.busy, 1'b1);
      check($sformatf("held_start done k=%0d", k), bus.done, (k == N + 1));
      if (k < N + 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("idle_gap busy_done", {bus.busy, bus.done}, 2'b00);
    @(posedge clk); #1;
    check("back_to_back accepted", bus.done, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    drain("held_start");
    $display("held_start mul 8x3 then add 100+100 done");

    // Reset in the middle of a multiply: immediate clear, no done pulse.
    @(posedge clk); #1;
    bus.op1 = 8'd200; bus.op2 = 8'd200; bus.cmd = 4'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("outputs_in_rst",
          {bus.busy, bus.done, bus.out, bus.out_hi, bus.over, bus.under, bus.err, bus.log}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    check("no_done_after_abort", obs_q.size(), 0);
    $display("reset abort of mul 200x200 done");

    issue(mk(8'd4, 8'd4, 4'd7, 8'd16, 8'd0, 0, 0, 0, 0));
    drain("mul_after_reset");
    $display("mul 4x4 after reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU, the sequential successor of the combinational N-bit ALU. It adds hardware unsigned multiply (shift-add) and divide (restoring) as iterative commands. Single-cycle operations run through the same start/done handshake. It serves as the arithmetic engine for testbench-driven and controller-driven datapaths that previously multiplied by repeated addition.

## Interface
- N, 8, operand/result width (N >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op1  input  N  operand A (unsigned)
- op2  input  N  operand B (unsigned)
- cmd  input  4  operation select
- busy  output  1  high while a request is in progress (RUN or DONE)
- done  output  1  one-cycle pulse; results valid from this cycle
- out  output  N  result / product low half / quotient
- out_hi  output  N  product high half / remainder; 0 for other commands
- over  output  1  carry out of add; product high half nonzero for mul
- under  output  1  borrow on sub (op1 < op2)
- err  output  1  illegal cmd or divide by zero
- log  output  1  comparison result

## Operation
- cmd encoding:
  - 0 add
  - 1 sub
  - 2 shl (op1 << op2)
  - 3 shr (op1 >> op2)
  - 4 eq
  - 5 gt
  - 6 lt
  - 7 mul
  - 8 div
  - 9–15 illegal
- States:
  - IDLE --start--> DONE (cmd 0–6, 9–15, or div with op2 == 0)
  - IDLE --start--> RUN (mul, or div with op2 != 0)
  - RUN --iteration counter reaches 0--> DONE
  - DONE --> IDLE unconditionally
- On accepted start: op1, op2 and cmd are captured. All result outputs and flags clear before the new result is written. Input changes after capture are ignored.
- Single-cycle commands:
  - add: out = sum mod 2^N; over = carry.
  - sub: out = difference mod 2^N; under = (op1 < op2).
  - shl/shr: shift is logical; op2 >= N gives out = 0.
  - eq/gt/lt: log only; out = 0.
  - illegal cmd: err = 1, out = 0.
- mul: N iterations, LSB-first shift-add over op2.
  - Full 2N-bit product: {out_hi, out}.
  - over = (out_hi != 0).
- div: N iterations, restoring.
  - out = quotient, out_hi = remainder.
  - op2 == 0: no iteration; err = 1, out = all ones, out_hi = op1.
- Results and flags hold from done until the next accepted start.
- start while busy is ignored; no queueing.

## Timing
- Reset (asynchronous, any state): state = IDLE; busy, done, out, out_hi, over, under, err, log all 0. Iteration counter and internal registers cleared.
- Reset mid-RUN aborts the operation; no done pulse is produced.
- start sampled at edge t:
  - Single-cycle commands and div-by-zero: done = 1 in the cycle after t (latency 1).
  - mul and div: RUN occupies N cycles; done = 1 at cycle t+N+1 (latency N+1).
- busy rises in the cycle after t and stays high through the DONE cycle.
- busy and done fall together.
- The earliest next accepted start is at the first edge after done drops, so back-to-back throughput is one request per (latency + 1) cycles.
- start high continuously: a new request is accepted each time IDLE is reached.
- Iteration counter is ceil(log2(N+1)) bits and counts N down to 1.

## Test plan
- N=8, mul 8 x 3, start pulse at t -> busy high t+1..t+9; done only at t+9; out = 0x18, out_hi = 0x00, over = 0.
- mul 255 x 255 -> out = 0x01, out_hi = 0xFE, over = 1.
- mul 0 x 200 -> out = 0, out_hi = 0, over = 0.
- div 200 / 7 -> out = 28, out_hi = 4, done at t+9.
- div 50 / 0 -> done at t+1; err = 1, out = 0xFF, out_hi = 50.
- add 200 + 100 -> out = 44, over = 1, done at t+1.
- sub 5 - 9 -> out = 252, under = 1.
- shl 1 << 9 -> out = 0.
- gt 9 > 5 -> log = 1.
- cmd 12 -> err = 1, out = 0.
- mul 8 x 3 started; start held high with new operands during RUN -> ignored; result still 0x18.
- On the edge after done -> next request accepted.
- mul in progress; rst pulse at t+4 -> all outputs 0 immediately; no done.
- A new mul 4 x 4 after reset -> out = 16.
